// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants, types and the modular-add helper used by
// the basecase multiplier datapath.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int BARRETT_K = 26;
  localparam int BARRETT_M = 20158;
  localparam int PROD_W    = 24;
  localparam int RES_W     = 12;

  typedef logic [RES_W-1:0]  coeff_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Group framing tags travelling alongside each beat through the pipeline.
  typedef struct packed {
    logic first;
    logic last;
  } tag_t;

  // Both operands are canonical, so one conditional subtract is enough.
  function automatic coeff_t mod_add_q(input coeff_t a, input coeff_t b);
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (RES_W+1)'(KYBER_Q)) s = s - (RES_W+1)'(KYBER_Q);
    return RES_W'(s);
  endfunction

endpackage

// File: rtl/mod_q_barrett.sv
// One-cycle registered Barrett reduction mod q for products below q^2.
module mod_q_barrett
  import kyber_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [PROD_W-1:0] x,
  output logic [RES_W-1:0]  r
);

  localparam int MUL_W  = PROD_W + 15;
  localparam int QUOT_W = MUL_W - BARRETT_K;
  localparam int SUB_W  = PROD_W + 2;

  logic [MUL_W-1:0]  xm;
  logic [QUOT_W-1:0] quot;
  logic [SUB_W-1:0]  qq;
  logic [SUB_W-1:0]  t;
  logic [SUB_W-1:0]  rr;

  // The quotient estimate can be one short, leaving t in [0, 2q).
  always_comb begin
    xm   = MUL_W'(x) * MUL_W'(BARRETT_M);
    quot = QUOT_W'(xm >> BARRETT_K);
    qq   = SUB_W'(quot) * SUB_W'(KYBER_Q);
    t    = SUB_W'(x) - qq;
    rr   = (t >= SUB_W'(KYBER_Q)) ? (t - SUB_W'(KYBER_Q)) : t;
  end

  always_ff @(posedge clk) begin
    if (en) r <= RES_W'(rr);
  end

endmodule

// File: rtl/basecase_mac_pipe.sv
// Pipelined multi-lane Kyber basecase multiplier over Z_q[X]/(X^2-gamma) with
// optional group accumulation; four register stages, globally stallable.
module basecase_mac_pipe
  import kyber_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int COEFF_W = 16,
  parameter int ACC_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [LANES*COEFF_W-1:0] in_a0,
  input  logic [LANES*COEFF_W-1:0] in_a1,
  input  logic [LANES*COEFF_W-1:0] in_b0,
  input  logic [LANES*COEFF_W-1:0] in_b1,
  input  logic [LANES*COEFF_W-1:0] in_gamma,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COEFF_W-1:0] out_c0,
  output logic [LANES*COEFF_W-1:0] out_c1,
  output logic                     grp_err
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high. out_valid stays up until out_ready; one global advance moves every
  // stage together, so a stalled output freezes the whole pipe including S1.
  logic advance, accept, take, emit;
  logic v1_q, v2_q, v3_q, out_valid_q;
  tag_t t1_q, t2_q, t3_q;
  logic grp_open_q, grp_err_q;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid & advance;
  assign take      = advance & v3_q;
  assign emit      = take & ((ACC_EN == 0) | t3_q.last);
  assign out_valid = out_valid_q;
  assign grp_err   = grp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      t1_q        <= '0;
      t2_q        <= '0;
      t3_q        <= '0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      t1_q        <= '{first: in_first, last: in_last};
      t2_q        <= t1_q;
      t3_q        <= t2_q;
      out_valid_q <= emit;
    end
  end

  // Group framing is tracked at acceptance so a restart is flagged immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_open_q <= 1'b0;
      grp_err_q  <= 1'b0;
    end else if (accept && (ACC_EN != 0)) begin
      if (in_first && grp_open_q) grp_err_q <= 1'b1;
      if (in_last)                grp_open_q <= 1'b0;
      else if (in_first)          grp_open_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [COEFF_W-1:0] a0_w, a1_w, b0_w, b1_w, g_w;
    coeff_t a0, a1, b0, b1, g0;
    prod_t  p00_q, p11_q, p01_q, p10_q, pg;
    coeff_t g1_q, g2_q;
    coeff_t r00, r11, r01, r10, rg;
    coeff_t r00_q, c1_q, c0_s;
    coeff_t acc0_q, acc1_q, nxt0, nxt1, oc0_q, oc1_q;

    assign a0_w = in_a0[i*COEFF_W +: COEFF_W];
    assign a1_w = in_a1[i*COEFF_W +: COEFF_W];
    assign b0_w = in_b0[i*COEFF_W +: COEFF_W];
    assign b1_w = in_b1[i*COEFF_W +: COEFF_W];
    assign g_w  = in_gamma[i*COEFF_W +: COEFF_W];
    assign a0   = RES_W'(a0_w);
    assign a1   = RES_W'(a1_w);
    assign b0   = RES_W'(b0_w);
    assign b1   = RES_W'(b1_w);
    assign g0   = RES_W'(g_w);

    // S1 products, gamma delay line, and the S3 alignment registers.
    always_ff @(posedge clk) begin
      if (advance) begin
        p00_q <= PROD_W'(a0) * PROD_W'(b0);
        p11_q <= PROD_W'(a1) * PROD_W'(b1);
        p01_q <= PROD_W'(a0) * PROD_W'(b1);
        p10_q <= PROD_W'(a1) * PROD_W'(b0);
        g1_q  <= g0;
        g2_q  <= g1_q;
        r00_q <= r00;
        c1_q  <= mod_add_q(r01, r10);
      end
    end

    mod_q_barrett u_r00 (.clk(clk), .en(advance), .x(p00_q), .r(r00));
    mod_q_barrett u_r11 (.clk(clk), .en(advance), .x(p11_q), .r(r11));
    mod_q_barrett u_r01 (.clk(clk), .en(advance), .x(p01_q), .r(r01));
    mod_q_barrett u_r10 (.clk(clk), .en(advance), .x(p10_q), .r(r10));

    assign pg = PROD_W'(r11) * PROD_W'(g2_q);

    mod_q_barrett u_rg (.clk(clk), .en(advance), .x(pg), .r(rg));

    assign c0_s = mod_add_q(r00_q, rg);

    always_comb begin
      nxt0 = c0_s;
      nxt1 = c1_q;
      if ((ACC_EN != 0) && !t3_q.first) begin
        nxt0 = mod_add_q(acc0_q, c0_s);
        nxt1 = mod_add_q(acc1_q, c1_q);
      end
    end

    // S4: the running sum includes the current beat before it is emitted.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc0_q <= '0;
        acc1_q <= '0;
        oc0_q  <= '0;
        oc1_q  <= '0;
      end else if (take) begin
        acc0_q <= nxt0;
        acc1_q <= nxt1;
        if (emit) begin
          oc0_q <= nxt0;
          oc1_q <= nxt1;
        end
      end
    end

    assign out_c0[i*COEFF_W +: COEFF_W] = COEFF_W'(oc0_q);
    assign out_c1[i*COEFF_W +: COEFF_W] = COEFF_W'(oc1_q);
  end

endmodule

// File: tb/tb_basecase_mac_pipe.sv
// Bench for basecase_mac_pipe: a plain (ACC_EN=0) and an accumulating
// (ACC_EN=1) 4-lane instance, selected by sel, scored against a formula model.
module tb_basecase_mac_pipe;

  localparam int Q  = 3329;
  localparam int L  = 4;
  localparam int W  = 16;
  localparam int BW = L * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_first, in_last, out_ready, sel, rdy_rand;
  logic [BW-1:0] in_a0, in_a1, in_b0, in_b1, in_gamma;
  logic          rp, ra, ovp, ova, ep, ea;
  logic [BW-1:0] c0p, c1p, c0a, c1a;

  logic          cur_ready, cur_valid, cur_err;
  logic [BW-1:0] cur_c0, cur_c1;

  basecase_mac_pipe #(.LANES(L), .COEFF_W(W), .ACC_EN(0)) u_plain (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rp),
    .in_first(in_first), .in_last(in_last),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_gamma(in_gamma),
    .out_valid(ovp), .out_ready(out_ready), .out_c0(c0p), .out_c1(c1p), .grp_err(ep)
  );

  basecase_mac_pipe #(.LANES(L), .COEFF_W(W), .ACC_EN(1)) u_acc (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ra),
    .in_first(in_first), .in_last(in_last),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1), .in_gamma(in_gamma),
    .out_valid(ova), .out_ready(out_ready), .out_c0(c0a), .out_c1(c1a), .grp_err(ea)
  );

  assign cur_ready = sel ? ra  : rp;
  assign cur_valid = sel ? ova : ovp;
  assign cur_err   = sel ? ea  : ep;
  assign cur_c0    = sel ? c0a : c0p;
  assign cur_c1    = sel ? c1a : c1p;

  int total = 0;
  int bad   = 0;
  logic [2*BW-1:0] exp_q[$];

  int a0[L], a1[L], b0[L], b1[L], g[L];
  int m_acc0[L], m_acc1[L];
  bit m_open, m_err;

  // ---------------- reference model ----------------
  function automatic void model_prod(input int x0, x1, y0, y1, gm,
                                     output int c0, output int c1);
    longint t;
    t  = longint'(x0) * y0 + longint'(x1) * y1 * gm;
    c0 = int'(t % Q);
    t  = longint'(x0) * y1 + longint'(x1) * y0;
    c1 = int'(t % Q);
  endfunction

  task automatic model_accept(input bit f, input bit l);
    int c0, c1;
    logic [BW-1:0] e0, e1;
    bit push;
    push = (sel == 1'b0) || l;
    if (sel && f && m_open) m_err = 1'b1;
    for (int i = 0; i < L; i++) begin
      model_prod(a0[i], a1[i], b0[i], b1[i], g[i], c0, c1);
      if (sel) begin
        m_acc0[i] = f ? c0 : (m_acc0[i] + c0) % Q;
        m_acc1[i] = f ? c1 : (m_acc1[i] + c1) % Q;
        c0 = m_acc0[i];
        c1 = m_acc1[i];
      end
      e0[i*W +: W] = W'(c0);
      e1[i*W +: W] = W'(c1);
    end
    if (sel) begin
      if (l)      m_open = 1'b0;
      else if (f) m_open = 1'b1;
    end
    if (push) exp_q.push_back({e1, e0});
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_acc0[i] = 0;
      m_acc1[i] = 0;
    end
    m_open = 1'b0;
    m_err  = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic set_all(input int x0, x1, y0, y1, gm);
    for (int i = 0; i < L; i++) begin
      a0[i] = x0; a1[i] = x1; b0[i] = y0; b1[i] = y1; g[i] = gm;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < L; i++) begin
      a0[i] = $urandom_range(0, Q-1); a1[i] = $urandom_range(0, Q-1);
      b0[i] = $urandom_range(0, Q-1); b1[i] = $urandom_range(0, Q-1);
      g[i]  = $urandom_range(0, Q-1);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit f, input bit l);
    int n;
    for (int i = 0; i < L; i++) begin
      in_a0[i*W +: W]    = W'(a0[i]);
      in_a1[i*W +: W]    = W'(a1[i]);
      in_b0[i*W +: W]    = W'(b0[i]);
      in_b1[i*W +: W]    = W'(b1[i]);
      in_gamma[i*W +: W] = W'(g[i]);
    end
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!cur_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", cur_ready, n);
      in_valid = 1'b0;
      return;
    end
    model_accept(f, l);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit found);
    int n;
    n = 0;
    while (!cur_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    found = cur_valid;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && cur_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: c0=%h c1=%h with no result outstanding", cur_c0, cur_c1);
      end else begin
        logic [2*BW-1:0] e;
        e = exp_q.pop_front();
        if ({cur_c1, cur_c0} !== e) begin
          bad++;
          $display("FAIL result: got c1c0=%h required %h (sel=%0b)", {cur_c1, cur_c0}, e, sel);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if ({ovp, ova, ep, ea} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: valid/err=%b required 0000", {ovp, ova, ep, ea});
    end
    total++;
    if ({c0p, c1p, c0a, c1a} !== '0) begin
      bad++;
      $display("FAIL reset_data: outputs nonzero, required 0");
    end
    total++;
    if ({rp, ra} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b required 11", {rp, ra});
    end
  endtask

  task automatic test_single();
    int n;
    sel = 1'b0;
    out_ready = 1'b1;
    set_all(245, 1023, 1864, 1825, 2285);
    send(1'b0, 1'b0);
    n = 1;
    while (!cur_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL single_latency: got %0d cycles required 4", n);
    end
    total++;
    if (cur_c0[W-1:0] !== 16'd1549 || cur_c1[W-1:0] !== 16'd394) begin
      bad++;
      $display("FAIL single_value: got %0d/%0d required 1549/394", cur_c0[W-1:0], cur_c1[W-1:0]);
    end
    drain();
  endtask

  task automatic test_accumulate();
    bit found;
    sel = 1'b1;
    set_all(245, 1023, 1864, 1825, 2285);
    send(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    total++;
    if (ova !== 1'b0) begin
      bad++;
      $display("FAIL acc_no_early_out: out_valid=%0b required 0", ova);
    end
    send(1'b0, 1'b1);
    wait_out(found);
    total++;
    if (!found || c0a[W-1:0] !== 16'd3098 || c1a[W-1:0] !== 16'd788) begin
      bad++;
      $display("FAIL acc_value: got %0d/%0d valid=%0b required 3098/788", c0a[W-1:0], c1a[W-1:0], found);
    end
    drain();
  endtask

  task automatic test_corners();
    bit found;
    int e0, e1;
    sel = 1'b1;
    set_all(3328, 3328, 3328, 3328, 3328);
    model_prod(3328, 3328, 3328, 3328, 3328, e0, e1);
    send(1'b1, 1'b1);
    wait_out(found);
    total++;
    if (!found || c0a[W-1:0] !== W'(e0) || c1a[W-1:0] !== 16'd2) begin
      bad++;
      $display("FAIL corner_wrap: got %0d/%0d required %0d/2", c0a[W-1:0], c1a[W-1:0], e0);
    end
    drain();
    set_all(0, 0, 0, 0, 0);
    send(1'b1, 1'b1);
    wait_out(found);
    total++;
    if (!found || c0a !== '0 || c1a !== '0) begin
      bad++;
      $display("FAIL corner_zero: got %h/%h required 0/0", c0a, c1a);
    end
    drain();
    set_all(1549, 0, 1, 0, 0);
    send(1'b1, 1'b0);
    set_all(1780, 0, 1, 0, 0);
    send(1'b0, 1'b1);
    wait_out(found);
    total++;
    if (!found || c0a[W-1:0] !== 16'd0 || c1a[W-1:0] !== 16'd0) begin
      bad++;
      $display("FAIL corner_acc_wrap: got %0d/%0d required 0/0", c0a[W-1:0], c1a[W-1:0]);
    end
    drain();
  endtask

  task automatic test_framing();
    bit found;
    int z0[L], z1[L], w0[L], w1[L];
    sel = 1'b1;
    total++;
    if (ea !== 1'b0) begin
      bad++;
      $display("FAIL framing_pre_err: grp_err=%0b required 0", ea);
    end
    set_random(); send(1'b1, 1'b0);
    set_random(); send(1'b0, 1'b0);
    set_random();
    for (int i = 0; i < L; i++) model_prod(a0[i], a1[i], b0[i], b1[i], g[i], z0[i], z1[i]);
    send(1'b1, 1'b0);
    set_random();
    for (int i = 0; i < L; i++) model_prod(a0[i], a1[i], b0[i], b1[i], g[i], w0[i], w1[i]);
    send(1'b0, 1'b1);
    wait_out(found);
    for (int i = 0; i < L; i++) begin
      total++;
      if (!found || c0a[i*W +: W] !== W'((z0[i] + w0[i]) % Q) ||
          c1a[i*W +: W] !== W'((z1[i] + w1[i]) % Q)) begin
        bad++;
        $display("FAIL framing_restart_sum lane%0d: got %0d/%0d required %0d/%0d", i,
                 c0a[i*W +: W], c1a[i*W +: W], (z0[i] + w0[i]) % Q, (z1[i] + w1[i]) % Q);
      end
    end
    total++;
    if (ea !== 1'b1) begin
      bad++;
      $display("FAIL framing_err: grp_err=%0b required 1", ea);
    end
    drain();
    set_random(); send(1'b1, 1'b1);
    drain();
    total++;
    if (ea !== 1'b1) begin
      bad++;
      $display("FAIL framing_sticky: grp_err=%0b required 1", ea);
    end
  endtask

  task automatic test_backpressure();
    int stalls;
    sel = 1'b0;
    out_ready = 1'b1;
    stalls = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          set_random();
          send(1'b0, 1'b0);
        end
      end
      begin
        int n;
        n = 0;
        while (!ovp && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (ovp) begin
            stalls++;
            total++;
            if (rp !== 1'b0) begin
              bad++;
              $display("FAIL bp_in_ready: in_ready=%0b while stalled, required 0", rp);
            end
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    total++;
    if (stalls != 5) begin
      bad++;
      $display("FAIL bp_stall_cycles: stalled %0d cycles required 5", stalls);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int seen;
    sel = 1'b1;
    out_ready = 1'b1;
    set_random(); send(1'b1, 1'b0);
    set_random(); send(1'b0, 1'b0);
    set_random(); send(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if (ova !== 1'b0 || c0a !== '0 || c1a !== '0 || ea !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: valid=%0b err=%0b c0=%h c1=%h required all 0", ova, ea, c0a, c1a);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ova) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_flush: %0d outputs after reset required 0", seen);
    end
    set_all(245, 1023, 1864, 1825, 2285);
    send(1'b1, 1'b1);
    wait_out(found);
    total++;
    if (!found || c0a[W-1:0] !== 16'd1549 || c1a[W-1:0] !== 16'd394) begin
      bad++;
      $display("FAIL reset_mid_fresh: got %0d/%0d required 1549/394", c0a[W-1:0], c1a[W-1:0]);
    end
    drain();
  endtask

  task automatic test_lanes4();
    bit found;
    int e0, e1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < L; i++) begin
        a0[i] = 100 * i + 7;  a1[i] = 3328 - 311 * i; b0[i] = 1000 + 555 * i;
        b1[i] = 17 + 801 * i; g[i]  = 2285 - 400 * i;
      end
      send(1'b1, 1'b1);
      wait_out(found);
      for (int i = 0; i < L; i++) begin
        model_prod(a0[i], a1[i], b0[i], b1[i], g[i], e0, e1);
        total++;
        if (!found || cur_c0[i*W +: W] !== W'(e0) || cur_c1[i*W +: W] !== W'(e1)) begin
          bad++;
          $display("FAIL lane%0d sel%0d: got %0d/%0d required %0d/%0d", i, s,
                   cur_c0[i*W +: W], cur_c1[i*W +: W], e0, e1);
        end
      end
      drain();
    end
  endtask

  task automatic test_random();
    int k, len;
    sel = 1'b0;
    rdy_rand = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      set_random();
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    sel = 1'b1;
    k = 0;
    while (k < 10000) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        set_random();
        send(j == 0, j == len - 1);
      end
      k += len;
    end
    drain();
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ea !== m_err) begin
      bad++;
      $display("FAIL random_grp_err: got %0b required %0b", ea, m_err);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; sel = 1'b0; rdy_rand = 1'b0;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0; in_gamma = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_accumulate();
    test_corners();
    test_framing();
    test_backpressure();
    test_reset_mid();
    test_lanes4();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
